// File: rtl/ofd_uart_framer.sv
// rtl/ofd_uart_framer.sv - capture FRAME_LEN samples into a FIFO and emit them as a framed UART byte stream
module ofd_uart_framer #(
  parameter int         N_BIT     = 12,
  parameter int         DEPTH     = 16,
  parameter int         FRAME_LEN = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig_start,
  input  logic             sample_en,
  input  logic [N_BIT-1:0] data_in,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_run,
  output logic             busy,
  output logic             overflow,
  output logic             frame_done
);

  localparam int NB = (N_BIT + 7) / 8;
  localparam int SW = 8 * NB;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [AW:0]    DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [BW-1:0]  LAST_IDX  = BW'(NB - 1);
  localparam logic [7:0]     LAST_SAMP = 8'(FRAME_LEN - 1);
  localparam logic [7:0]     LEN_BYTE  = 8'(FRAME_LEN);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_SAMP, S_CSUM, S_DONE} state_t;
  state_t state, state_nxt;

  logic [N_BIT-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty;

  logic             armed;
  logic [7:0]       acc_cnt;
  logic [7:0]       samp_cnt;
  logic [BW-1:0]    byte_idx;
  logic [SW-1:0]    shift;
  logic [1:0]       guard;
  logic [7:0]       csum;

  logic             trig_ok, push_req, push, reject;
  logic             can_send, issue, pop;
  logic [7:0]       byte_nxt;
  logic [SW-1:0]    head_ext;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign busy     = (state != S_IDLE);
  assign trig_ok  = trig_start && (state == S_IDLE);
  // Fullness is judged before any same-cycle pop, so a pop never makes room for a push.
  assign push_req = armed && sample_en;
  assign push     = push_req && !full;
  assign reject   = push_req && full;
  assign can_send = tx_ready && (guard == 2'd0);
  assign head_ext = SW'(mem[rd_ptr]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    pop       = 1'b0;
    byte_nxt  = 8'h00;
    case (state)
      S_IDLE: begin
        if (trig_start) state_nxt = S_SYNC;
      end
      S_SYNC: begin
        if (can_send) begin
          issue     = 1'b1;
          byte_nxt  = SYNC_BYTE;
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (can_send) begin
          issue     = 1'b1;
          byte_nxt  = LEN_BYTE;
          state_nxt = S_SAMP;
        end
      end
      S_SAMP: begin
        // The first byte of each sample comes straight from the FIFO head; stall while it is empty.
        if (can_send && ((byte_idx != '0) || !empty)) begin
          issue    = 1'b1;
          pop      = (byte_idx == '0);
          byte_nxt = (byte_idx == '0) ? head_ext[7:0] : shift[7:0];
          if ((byte_idx == LAST_IDX) && (samp_cnt == LAST_SAMP)) state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (can_send) begin
          issue     = 1'b1;
          byte_nxt  = csum;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed    <= 1'b0;
      acc_cnt  <= 8'd0;
      overflow <= 1'b0;
    end else if (trig_ok) begin
      armed    <= 1'b1;
      acc_cnt  <= 8'd0;
      overflow <= 1'b0;
    end else if (push) begin
      acc_cnt <= acc_cnt + 8'd1;
      if (acc_cnt == LAST_SAMP) armed <= 1'b0;
    end else if (reject) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data    <= 8'h00;
      tx_run     <= 1'b0;
      frame_done <= 1'b0;
      guard      <= 2'd0;
      samp_cnt   <= 8'd0;
      byte_idx   <= '0;
      shift      <= '0;
      csum       <= 8'h00;
    end else begin
      tx_run     <= issue;
      frame_done <= (state == S_DONE);
      if (issue) tx_data <= byte_nxt;
      // A fresh issue blocks the next one for three cycles, giving a four-cycle byte pitch.
      if (issue) begin
        guard <= 2'd3;
      end else if (trig_ok) begin
        guard <= 2'd1;
      end else if (guard != 2'd0) begin
        guard <= guard - 2'd1;
      end
      if (trig_ok) begin
        samp_cnt <= 8'd0;
        byte_idx <= '0;
        csum     <= 8'h00;
      end else if (issue && (state == S_LEN)) begin
        csum <= LEN_BYTE;
      end else if (issue && (state == S_SAMP)) begin
        csum  <= csum + byte_nxt;
        shift <= (byte_idx == '0) ? (head_ext >> 8) : (shift >> 8);
        if (byte_idx == LAST_IDX) begin
          byte_idx <= '0;
          samp_cnt <= samp_cnt + 8'd1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ofd_uart_framer.sv
// tb/tb_ofd_uart_framer.sv - directed self-checking bench for ofd_uart_framer
module tb_ofd_uart_framer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic        trig_a = 0, se_a = 0, rdy_a = 1;
  logic [11:0] din_a = '0;
  logic [7:0]  txd_a;
  logic        run_a, busy_a, ovf_a, fd_a;

  logic        trig_b = 0, se_b = 0, rdy_b = 1;
  logic [11:0] din_b = '0;
  logic [7:0]  txd_b;
  logic        run_b, busy_b, ovf_b, fd_b;

  logic        trig_c = 0, se_c = 0, rdy_c = 1;
  logic [11:0] din_c = '0;
  logic [7:0]  txd_c;
  logic        run_c, busy_c, ovf_c, fd_c;

  ofd_uart_framer #(.N_BIT(12), .DEPTH(16), .FRAME_LEN(2)) u_a (
    .clk(clk), .reset(rst), .trig_start(trig_a), .sample_en(se_a), .data_in(din_a),
    .tx_ready(rdy_a), .tx_data(txd_a), .tx_run(run_a), .busy(busy_a),
    .overflow(ovf_a), .frame_done(fd_a));

  ofd_uart_framer u_b (
    .clk(clk), .reset(rst), .trig_start(trig_b), .sample_en(se_b), .data_in(din_b),
    .tx_ready(rdy_b), .tx_data(txd_b), .tx_run(run_b), .busy(busy_b),
    .overflow(ovf_b), .frame_done(fd_b));

  ofd_uart_framer #(.N_BIT(12), .DEPTH(2), .FRAME_LEN(4)) u_c (
    .clk(clk), .reset(rst), .trig_start(trig_c), .sample_en(se_c), .data_in(din_c),
    .tx_ready(rdy_c), .tx_data(txd_c), .tx_run(run_c), .busy(busy_c),
    .overflow(ovf_c), .frame_done(fd_c));

  logic [7:0] bq_a[$], bq_b[$], bq_c[$];
  int         rc_a[$];
  int         nd_a = 0, nd_b = 0, nd_c = 0;
  int         dc_a = 0;
  logic       bd_a = 1'b1;

  always @(negedge clk) begin
    if (run_a) begin bq_a.push_back(txd_a); rc_a.push_back(cyc); end
    if (run_b) bq_b.push_back(txd_b);
    if (run_c) bq_c.push_back(txd_c);
    if (fd_a) begin nd_a++; dc_a = cyc; bd_a = busy_a; end
    if (fd_b) nd_b++;
    if (fd_c) nd_c++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_cmp++;
    if ({txd_a, run_a, busy_a, ovf_a, fd_a} !== 12'h000) begin
      n_bad++; $display("FAIL reset_a: got %h want 000", {txd_a, run_a, busy_a, ovf_a, fd_a});
    end
    n_cmp++;
    if ({txd_b, run_b, busy_b, ovf_b, fd_b} !== 12'h000) begin
      n_bad++; $display("FAIL reset_b: got %h want 000", {txd_b, run_b, busy_b, ovf_b, fd_b});
    end
    n_cmp++;
    if ({txd_c, run_c, busy_c, ovf_c, fd_c} !== 12'h000) begin
      n_bad++; $display("FAIL reset_c: got %h want 000", {txd_c, run_c, busy_c, ovf_c, fd_c});
    end
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_frame();
    logic [7:0] exp[$];
    logic [7:0] got;
    int k;
    bq_a.delete(); rc_a.delete(); nd_a = 0;
    trig_a = 1; step(); k = cyc; trig_a = 0;
    n_cmp++;
    if (busy_a !== 1'b1) begin n_bad++; $display("FAIL t1_busy_rise: got %b want 1", busy_a); end
    se_a = 1; din_a = 12'h123; step();
    din_a = 12'hABC; step();
    se_a = 0;
    for (int i = 0; i < 200 && nd_a == 0; i++) step();
    repeat (3) step();
    exp = '{8'hA5, 8'h02, 8'h23, 8'h01, 8'hBC, 8'h0A, 8'hEC};
    n_cmp++;
    if (bq_a.size() != exp.size()) begin
      n_bad++; $display("FAIL t1_count: got %0d want %0d", bq_a.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < bq_a.size()) ? bq_a[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin n_bad++; $display("FAIL t1_byte%0d: got %h want %h", i, got, exp[i]); end
    end
    if (rc_a.size() == 7) begin
      n_cmp++;
      if (rc_a[0] != k + 2) begin n_bad++; $display("FAIL t1_sync_latency: got %0d want %0d", rc_a[0] - k, 2); end
      for (int i = 1; i < 7; i++) begin
        n_cmp++;
        if (rc_a[i] - rc_a[i-1] != 4) begin
          n_bad++; $display("FAIL t1_spacing%0d: got %0d want 4", i, rc_a[i] - rc_a[i-1]);
        end
      end
      n_cmp++;
      if (dc_a != rc_a[6] + 1) begin n_bad++; $display("FAIL t1_done_cycle: got %0d want %0d", dc_a, rc_a[6] + 1); end
    end
    n_cmp++;
    if (nd_a != 1) begin n_bad++; $display("FAIL t1_done_count: got %0d want 1", nd_a); end
    n_cmp++;
    if (bd_a !== 1'b0) begin n_bad++; $display("FAIL t1_busy_at_done: got %b want 0", bd_a); end
    n_cmp++;
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL t1_busy_after: got %b want 0", busy_a); end
  endtask

  task automatic test_defaults();
    logic [7:0] exp[$];
    logic [7:0] got;
    bq_b.delete(); nd_b = 0;
    trig_b = 1; step(); trig_b = 0;
    se_b = 1;
    for (int i = 0; i < 8; i++) begin din_b = 12'(i); step(); end
    se_b = 0;
    for (int i = 0; i < 300 && nd_b == 0; i++) step();
    step();
    exp = '{8'hA5, 8'h08};
    for (int i = 0; i < 8; i++) begin exp.push_back(8'(i)); exp.push_back(8'h00); end
    exp.push_back(8'h24);
    n_cmp++;
    if (bq_b.size() != 19) begin n_bad++; $display("FAIL t2_count: got %0d want 19", bq_b.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < bq_b.size()) ? bq_b[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin n_bad++; $display("FAIL t2_byte%0d: got %h want %h", i, got, exp[i]); end
    end
    n_cmp++;
    if (ovf_b !== 1'b0) begin n_bad++; $display("FAIL t2_overflow: got %b want 0", ovf_b); end
    n_cmp++;
    if (nd_b != 1) begin n_bad++; $display("FAIL t2_done_count: got %0d want 1", nd_b); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp[$];
    logic [7:0] got;
    bq_c.delete(); nd_c = 0;
    rdy_c = 0;
    trig_c = 1; step(); trig_c = 0;
    se_c = 1;
    for (int i = 1; i <= 6; i++) begin din_c = 12'(i * 12'h101); step(); end
    se_c = 0;
    repeat (44) step();
    n_cmp++;
    if (ovf_c !== 1'b1) begin n_bad++; $display("FAIL t3_overflow_set: got %b want 1", ovf_c); end
    n_cmp++;
    if (bq_c.size() != 0) begin n_bad++; $display("FAIL t3_no_tx_while_not_ready: got %0d want 0", bq_c.size()); end
    rdy_c = 1;
    repeat (3) step();
    trig_c = 1; step(); trig_c = 0;
    n_cmp++;
    if (ovf_c !== 1'b1) begin n_bad++; $display("FAIL t3_midframe_trig_clear: got %b want 1", ovf_c); end
    repeat (22) step();
    se_c = 1; din_c = 12'h707; step();
    din_c = 12'h808; step();
    se_c = 0;
    for (int i = 0; i < 300 && nd_c == 0; i++) step();
    step();
    exp = '{8'hA5, 8'h04, 8'h01, 8'h01, 8'h02, 8'h02, 8'h07, 8'h07, 8'h08, 8'h08, 8'h28};
    n_cmp++;
    if (bq_c.size() != exp.size()) begin
      n_bad++; $display("FAIL t3_count: got %0d want %0d", bq_c.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < bq_c.size()) ? bq_c[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin n_bad++; $display("FAIL t3_byte%0d: got %h want %h", i, got, exp[i]); end
    end
    n_cmp++;
    if (nd_c != 1) begin n_bad++; $display("FAIL t3_done_count: got %0d want 1", nd_c); end
    n_cmp++;
    if (ovf_c !== 1'b1) begin n_bad++; $display("FAIL t3_overflow_sticky: got %b want 1", ovf_c); end
  endtask

  task automatic test_stall();
    logic [7:0] exp[$];
    logic [7:0] got;
    int k;
    bq_a.delete(); rc_a.delete(); nd_a = 0;
    trig_a = 1; step(); k = cyc; trig_a = 0;
    se_a = 1; din_a = 12'h0F5; step();
    se_a = 0;
    repeat (48) step();
    n_cmp++;
    if (bq_a.size() != 4) begin n_bad++; $display("FAIL t4_stall_count: got %0d want 4", bq_a.size()); end
    if (rc_a.size() > 0) begin
      n_cmp++;
      if (rc_a[rc_a.size()-1] != k + 14) begin
        n_bad++; $display("FAIL t4_last_before_stall: got %0d want %0d", rc_a[rc_a.size()-1] - k, 14);
      end
    end
    n_cmp++;
    if (busy_a !== 1'b1) begin n_bad++; $display("FAIL t4_busy_in_stall: got %b want 1", busy_a); end
    se_a = 1; din_a = 12'h3C6; step();
    se_a = 0;
    for (int i = 0; i < 200 && nd_a == 0; i++) step();
    step();
    exp = '{8'hA5, 8'h02, 8'hF5, 8'h00, 8'hC6, 8'h03, 8'hC0};
    n_cmp++;
    if (bq_a.size() != exp.size()) begin
      n_bad++; $display("FAIL t4_count: got %0d want %0d", bq_a.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < bq_a.size()) ? bq_a[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin n_bad++; $display("FAIL t4_byte%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[$];
    logic [7:0] got;
    bq_b.delete(); nd_b = 0;
    trig_b = 1; step(); trig_b = 0;
    se_b = 1;
    for (int i = 0; i < 8; i++) begin din_b = 12'(16 + i); step(); end
    se_b = 0;
    repeat (4) step();
    n_cmp++;
    if (txd_b !== 8'h10) begin n_bad++; $display("FAIL t5_before_reset: got %h want 10", txd_b); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({txd_b, run_b, busy_b, ovf_b, fd_b} !== 12'h000) begin
      n_bad++; $display("FAIL t5_async_clear: got %h want 000", {txd_b, run_b, busy_b, ovf_b, fd_b});
    end
    step();
    rst = 1'b0;
    repeat (20) step();
    n_cmp++;
    if (nd_b != 0 || bq_b.size() != 3) begin
      n_bad++; $display("FAIL t5_aborted: got done=%0d bytes=%0d want done=0 bytes=3", nd_b, bq_b.size());
    end
    bq_b.delete();
    trig_b = 1; step(); trig_b = 0;
    se_b = 1;
    for (int i = 0; i < 8; i++) begin din_b = 12'h120 + 12'(i); step(); end
    se_b = 0;
    for (int i = 0; i < 300 && nd_b == 0; i++) step();
    step();
    exp = '{8'hA5, 8'h08};
    for (int i = 0; i < 8; i++) begin exp.push_back(8'h20 + 8'(i)); exp.push_back(8'h01); end
    exp.push_back(8'h2C);
    n_cmp++;
    if (bq_b.size() != 19) begin n_bad++; $display("FAIL t5_count: got %0d want 19", bq_b.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < bq_b.size()) ? bq_b[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin n_bad++; $display("FAIL t5_byte%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    logic [7:0] got;
    bq_a.delete(); rc_a.delete(); nd_a = 0;
    trig_a = 1; step(); trig_a = 0;
    se_a = 1; din_a = 12'h123; step();
    din_a = 12'hABC; step();
    se_a = 0;
    repeat (5) step();
    trig_a = 1; se_a = 1; din_a = 12'h999; step();
    trig_a = 0; step();
    se_a = 0;
    for (int i = 0; i < 200 && fd_a !== 1'b1; i++) step();
    n_cmp++;
    if (fd_a !== 1'b1) begin n_bad++; $display("FAIL t6_first_done: got %b want 1", fd_a); end
    trig_a = 1; step(); trig_a = 0;
    se_a = 1; din_a = 12'h456; step();
    din_a = 12'h789; step();
    se_a = 0;
    for (int i = 0; i < 200 && nd_a < 2; i++) step();
    step();
    exp = '{8'hA5, 8'h02, 8'h23, 8'h01, 8'hBC, 8'h0A, 8'hEC,
            8'hA5, 8'h02, 8'h56, 8'h04, 8'h89, 8'h07, 8'hEC};
    n_cmp++;
    if (bq_a.size() != exp.size()) begin
      n_bad++; $display("FAIL t6_count: got %0d want %0d", bq_a.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < bq_a.size()) ? bq_a[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin n_bad++; $display("FAIL t6_byte%0d: got %h want %h", i, got, exp[i]); end
    end
    if (rc_a.size() >= 8) begin
      n_cmp++;
      if (rc_a[7] - rc_a[6] != 4) begin
        n_bad++; $display("FAIL t6_b2b_gap: got %0d want 4", rc_a[7] - rc_a[6]);
      end
    end
    n_cmp++;
    if (nd_a != 2) begin n_bad++; $display("FAIL t6_done_count: got %0d want 2", nd_a); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_defaults();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
